// File: rtl/graph_lut_stream_fp16.sv
// FP16 stream through an external fixed-latency activation LUT: tags follow each
// lookup through the LUT pipeline and results land in a FIFO that can never overflow.
module graph_lut_stream_fp16 #(
    parameter int LUT_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic [7:0]       lut_addr,
    input  logic [15:0]      lut_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             len_err,
    output logic [1:0]       state_dbg
);
    localparam int DEPTH = LUT_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len_q, in_cnt;
    logic [LUT_LAT-1:0] tag_v, tag_l;
    logic [15:0]      fifo_mem [DEPTH];
    logic [DEPTH-1:0] fifo_last;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    fifo_cnt, inflight;
    logic             len_err_q;
    logic             start_ok, in_hs, last_elem, fifo_wr, fifo_pop;
    logic             unused_lsbs;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Both streams transfer a word in any cycle where valid and ready are high
    // together; valid never depends on ready, and in_ready never sees out_ready.
    assign start_ok  = start && (state == S_IDLE);
    assign in_hs     = in_valid && in_ready;
    assign last_elem = ((in_cnt + CNT_W'(1)) == len_q);
    assign fifo_wr   = tag_v[LUT_LAT-1];
    assign fifo_pop  = out_valid && out_ready;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LUT_LAT; i++) begin
            inflight = inflight + CW'(tag_v[i]);
        end
    end

    // Reserve a FIFO slot for every lookup still inside the LUT pipeline.
    assign in_ready  = (state == S_RUN) &&
                       (((CW+1)'(fifo_cnt) + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
    assign lut_addr  = in_data[15:8];
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : 16'h0000;
    assign out_last  = out_valid && fifo_last[rd_ptr];
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign len_err   = len_err_q;
    assign state_dbg = state;
    assign unused_lsbs = ^in_data[7:0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (in_hs && last_elem) state_nxt = S_DRAIN;
            S_DRAIN: if (fifo_pop && out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_q     <= '0;
            in_cnt    <= '0;
            tag_v     <= '0;
            tag_l     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            len_err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                len_q     <= len;
                in_cnt    <= '0;
                len_err_q <= 1'b0;
            end else if (in_hs) begin
                in_cnt <= in_cnt + CNT_W'(1);
                if (in_last != last_elem) len_err_q <= 1'b1;
            end
            tag_v[0] <= in_hs;
            tag_l[0] <= in_hs && last_elem;
            for (int i = 1; i < LUT_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            if (fifo_wr)  wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
            if (fifo_wr && !fifo_pop)      fifo_cnt <= fifo_cnt + CW'(1);
            else if (!fifo_wr && fifo_pop) fifo_cnt <= fifo_cnt - CW'(1);
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr]  <= lut_data;
            fifo_last[wr_ptr] <= tag_l[LUT_LAT-1];
        end
    end

endmodule

// File: tb/tb_graph_lut_stream_fp16.sv
// Bench for graph_lut_stream_fp16: an exp-style LUT model, a scoreboard fed at input
// handshakes, a table of single-element jobs and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_graph_lut_stream_fp16;
    localparam int LUT_LAT = 1;
    localparam int CNT_W   = 16;
    localparam int LAT     = LUT_LAT + 1;

    logic             clk = 1'b0;
    logic             rst_n, start, in_valid, in_ready, in_last;
    logic [CNT_W-1:0] len;
    logic [15:0]      in_data, lut_data, out_data;
    logic [7:0]       lut_addr;
    logic             out_valid, out_ready, out_last, busy, done, len_err;
    logic [1:0]       state_dbg;

    always #5 clk = ~clk;

    graph_lut_stream_fp16 #(.LUT_LAT(LUT_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .len_err(len_err), .state_dbg(state_dbg)
    );

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          job_len  = 0;
    int          sb_idx   = 0;
    int          ready_cnt = 0;
    int          valid_cnt = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    int          hs_cyc[$];
    int          pop_cyc[$];
    int          done_cyc[$];
    logic        hold_prev = 1'b0;
    logic [16:0] prev_out  = '0;
    logic        sends_done;
    logic        rand_bp;
    vec_t        vecs[5];
    logic [15:0] bp_data[8];

    function automatic logic [15:0] lut_fn(input logic [7:0] a);
        case (a)
            8'h3C:   return 16'h4170;
            8'hBC:   return 16'h35E3;
            8'h7C:   return 16'h7C00;
            8'hFC:   return 16'h0000;
            8'h00:   return 16'h3C00;
            default: return {a ^ 8'hA5, ~a};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // clock/reset side processes: cycle counter and LUT with LUT_LAT=1
    initial forever begin
        @(posedge clk);
        cyc++;
        lut_data <= lut_fn(lut_addr);
    end

    // monitor + scoreboard
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (in_ready)  ready_cnt++;
            if (out_valid) valid_cnt++;
            if (done) done_cyc.push_back(cyc);
            if (hold_prev)
                check("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_out}));
            hold_prev = out_valid && !out_ready;
            prev_out  = {out_last, out_data};
            if (in_valid && in_ready) begin
                exp_q.push_back({(sb_idx == job_len - 1), lut_fn(in_data[15:8])});
                hs_cyc.push_back(cyc);
                sb_idx++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back({out_last, out_data});
                pop_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h with nothing expected", {out_last, out_data});
                end else begin
                    check("scoreboard", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic start_job(input int l);
        @(posedge clk); #1;
        start = 1'b1; len = CNT_W'(l); job_len = l; sb_idx = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic last);
        int waited = 0;
        in_valid = 1'b1; in_data = d; in_last = last;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for data 0x%0h", d);
            in_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        got_q.delete(); hs_cyc.delete(); pop_cyc.delete(); done_cyc.delete();
        ready_cnt = 0; valid_cnt = 0;
    endtask

    task automatic single_job(input string tag);
        int first_hs, first_pop, first_done;
        logic [16:0] got0;
        clear_logs();
        start_job(1);
        send(16'h3C00, 1'b1);
        idle_in();
        wait_idle({tag, "_idle"});
        first_hs   = (hs_cyc.size()   > 0) ? hs_cyc[0]   : -100;
        first_pop  = (pop_cyc.size()  > 0) ? pop_cyc[0]  : -200;
        first_done = (done_cyc.size() > 0) ? done_cyc[0] : -300;
        got0       = (got_q.size()    > 0) ? got_q[0]    : 17'h0;
        check({tag, "_out"},        32'(got0), 32'({1'b1, 16'h4170}));
        check({tag, "_latency"},    32'(first_pop - first_hs), 32'(LAT));
        check({tag, "_done_cycle"}, 32'(first_done - first_pop), 32'd1);
        check({tag, "_done_count"}, 32'(done_cyc.size()), 32'd1);
    endtask

    initial begin
        int n;
        logic [16:0] g;
        logic [15:0] d;
        int l;

        vecs[0] = '{din: 16'h3C00, dout: 16'h4170};
        vecs[1] = '{din: 16'h0000, dout: 16'h3C00};
        vecs[2] = '{din: 16'hBC00, dout: 16'h35E3};
        vecs[3] = '{din: 16'h7C00, dout: 16'h7C00};
        vecs[4] = '{din: 16'hFC00, dout: 16'h0000};

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = 16'hA7C3; in_last = 1'b0; out_ready = 1'b1; rand_bp = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_len_err",   32'(len_err),   32'd0);
        check("rst_lut_addr",  32'(lut_addr),  32'h0000_00A7);
        check("rst_state",     32'(state_dbg), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        single_job("single");

        // table of single-element jobs
        for (int i = 0; i < 5; i++) begin
            clear_logs();
            start_job(1);
            send(vecs[i].din, 1'b1);
            idle_in();
            wait_idle("table_idle");
            g = (got_q.size() > 0) ? got_q[0] : 17'h0;
            check("table_out", 32'(g), 32'({1'b1, vecs[i].dout}));
        end

        // back-to-back streaming
        clear_logs();
        start_job(4);
        for (int i = 0; i < 4; i++) send(vecs[i+1].din, (i == 3));
        idle_in();
        wait_idle("stream_idle");
        check("stream_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            g = (got_q.size() > i) ? got_q[i] : 17'h0;
            check("stream_out", 32'(g), 32'({(i == 3), vecs[i+1].dout}));
        end
        check("stream_out_spacing", 32'((pop_cyc.size() == 4) ? pop_cyc[3] - pop_cyc[0] : -1), 32'd3);
        check("stream_in_spacing",  32'((hs_cyc.size()  == 4) ? hs_cyc[3]  - hs_cyc[0]  : -1), 32'd3);

        // backpressure
        clear_logs();
        for (int i = 0; i < 8; i++) bp_data[i] = 16'($urandom_range(0, 16'hFFFF));
        out_ready = 1'b0;
        start_job(8);
        sends_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(bp_data[i], (i == 7));
                idle_in();
                sends_done = 1'b1;
            end
        join_none
        repeat (8) @(negedge clk);
        check("bp_accepted", 32'(hs_cyc.size()), 32'd3);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head", 32'({out_valid, out_data}), 32'({1'b1, lut_fn(bp_data[0][15:8])}));
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        while (!sends_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("bp_sends_done", 32'(sends_done), 32'd1);
        @(posedge clk); #1;
        wait_idle("bp_idle");
        check("bp_count", 32'(got_q.size()), 32'd8);

        // framing error plus a start while busy
        clear_logs();
        start_job(3);
        send(16'h1100, 1'b0);
        idle_in();
        start = 1'b1; len = CNT_W'(1);
        @(posedge clk); #1;
        start = 1'b0;
        send(16'h2200, 1'b1);
        check("frame_err_set", 32'(len_err), 32'd1);
        send(16'h3300, 1'b0);
        idle_in();
        wait_idle("frame_idle");
        check("frame_count", 32'(got_q.size()), 32'd3);
        g = (got_q.size() > 2) ? got_q[2] : 17'h0;
        check("frame_last", 32'(g[16]), 32'd1);
        check("frame_err_sticky", 32'(len_err), 32'd1);
        start_job(1);
        check("frame_err_cleared", 32'(len_err), 32'd0);
        send(16'h3C00, 1'b1);
        idle_in();
        wait_idle("frame2_idle");
        check("frame2_no_err", 32'(len_err), 32'd0);

        // len == 0
        clear_logs();
        start_job(0);
        @(negedge clk);
        check("len0_done", 32'({done, busy}), 32'b11);
        @(negedge clk);
        check("len0_after", 32'({done, busy}), 32'b00);
        check("len0_no_ready", 32'(ready_cnt), 32'd0);
        check("len0_done_count", 32'(done_cyc.size()), 32'd1);
        @(posedge clk); #1;

        // mid-job reset with buffered elements and a raised len_err
        clear_logs();
        out_ready = 1'b0;
        start_job(6);
        send(16'h4400, 1'b1);
        send(16'h5500, 1'b0);
        send(16'h6600, 1'b0);
        idle_in();
        check("mrst_err_before", 32'(len_err), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_out_data",  32'(out_data),  32'd0);
        check("mrst_out_last",  32'(out_last),  32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd0);
        check("mrst_busy_done", 32'({busy, done}), 32'd0);
        check("mrst_len_err",   32'(len_err),   32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        valid_cnt = 0;
        repeat (10) @(negedge clk);
        check("mrst_no_stale", 32'(valid_cnt), 32'd0);
        @(posedge clk); #1;
        single_job("after_rst");

        // random jobs under random backpressure
        rand_bp = 1'b1;
        fork
            begin
                while (rand_bp) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int j = 0; j < 4; j++) begin
            clear_logs();
            l = $urandom_range(1, 7);
            start_job(l);
            for (int i = 0; i < l; i++) begin
                d = 16'($urandom_range(0, 16'hFFFF));
                send(d, (i == l - 1));
            end
            idle_in();
            wait_idle("rand_idle");
            check("rand_count", 32'(got_q.size()), 32'(l));
            check("rand_no_err", 32'(len_err), 32'd0);
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
